// File: rtl/hf_pkg.sv
// rtl/hf_pkg.sv - shared HF image constants, mode codes and latency FSM state type
package hf_pkg;

   localparam logic [2:0] SNIFFER       = 3'd0;
   localparam logic [2:0] TAGSIM_LISTEN = 3'd1;
   localparam logic [2:0] TAGSIM_MOD    = 3'd2;
   localparam logic [2:0] READER_LISTEN = 3'd3;
   localparam logic [2:0] READER_MOD    = 3'd4;

   localparam int DEFAULT_THRESHOLD = 40;

   typedef enum logic {
      LAT_IDLE = 1'b0,
      LAT_RUN  = 1'b1
   } lat_state_e;

endpackage

// File: rtl/hf_edge_filter.sv
// rtl/hf_edge_filter.sv - four-deep ADC history and 5-tap Gaussian-derivative edge filter
module hf_edge_filter
   import hf_pkg::*;
#(
   parameter int ADC_W = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [ADC_W-1:0]        adc_d,
   output logic signed [ADC_W+2:0] f
);

   logic [ADC_W-1:0] p1_q, p2_q, p3_q, p4_q;
   logic [ADC_W-1:0] p1_d, p2_d, p3_d, p4_d;
   logic [ADC_W+2:0] pos_sum, neg_sum;

   always_comb begin
      p1_d = adc_d;
      p2_d = p1_q;
      p3_d = p2_q;
      p4_d = p3_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         p1_q <= '0;
         p2_q <= '0;
         p3_q <= '0;
         p4_q <= '0;
      end else begin
         p1_q <= p1_d;
         p2_q <= p2_d;
         p3_q <= p3_d;
         p4_q <= p4_d;
      end
   end

   // Center tap p2 carries zero weight; it only delays the history.
   always_comb begin
      pos_sum = ({3'b000, p4_q} << 1) + {3'b000, p3_q};
      neg_sum = ({3'b000, adc_d} << 1) + {3'b000, p1_q};
      f       = $signed(pos_sum - neg_sum);
   end

endmodule

// File: rtl/hf_subcarrier_demod.sv
// rtl/hf_subcarrier_demod.sv - reader-side subcarrier detector, SSP framer, response latency timer
// Optional latency FSM/counter built only when HF_DEMOD_TIMESTAMP_EN is defined.
module hf_subcarrier_demod
   import hf_pkg::*;
#(
   parameter int ADC_W      = 8,
   parameter int SUBC_LOG2  = 4,
   parameter int FRAME_LOG2 = 3,
   parameter int TS_W       = 16
) (
   input  logic                   ck_1356meg,
   input  logic                   rst,
   input  logic                   enable,
   input  logic [ADC_W-1:0]       adc_d,
   input  logic [ADC_W+1:0]       threshold,
   input  logic [SUBC_LOG2-1:0]   detect_phase,
   input  logic                   mod_sig,
   output logic                   curbit,
   output logic                   ssp_clk,
   output logic                   ssp_frame,
   output logic                   ssp_din,
   output logic [(1<<FRAME_LOG2)-1:0] frame_word,
   output logic                   frame_valid,
   output logic [TS_W-1:0]        resp_latency,
   output logic                   resp_latency_valid
);

   localparam int CW = SUBC_LOG2 + FRAME_LOG2;
   localparam int P  = 1 << SUBC_LOG2;
   localparam int FB = 1 << FRAME_LOG2;
   localparam int FW = ADC_W + 3;

   localparam logic [CW-1:0]        CNT_LAST = CW'(P * (FB - 1));
   localparam logic [CW-1:0]        FR_SET   = CW'(P / 2 - 1);
   localparam logic [CW-1:0]        FR_CLR   = CW'(P / 2 - 1 + P);
   localparam logic [SUBC_LOG2-1:0] HALF_PH  = SUBC_LOG2'(P / 2);
   localparam logic signed [FW-1:0] ZERO_F   = '0;

   logic signed [FW-1:0] f;
   logic signed [FW-1:0] thr_s, thr_neg;
   logic [SUBC_LOG2-1:0] phase;

   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 curbit_q, curbit_d;
   logic signed [FW-1:0] fall_max_q, fall_max_d;
   logic signed [FW-1:0] rise_min_q, rise_min_d;
   logic [FB-1:0]        shift_q, shift_d;
   logic [FB-1:0]        frame_word_q, frame_word_d;
   logic                 frame_valid_q, frame_valid_d;
   logic                 ssp_clk_q, ssp_clk_d;
   logic                 ssp_frame_q, ssp_frame_d;
   logic                 ssp_din_q, ssp_din_d;

   hf_edge_filter #(.ADC_W(ADC_W)) u_filter (
      .clk   (ck_1356meg),
      .rst   (rst),
      .adc_d (adc_d),
      .f     (f)
   );

   assign phase   = cnt_q[SUBC_LOG2-1:0];
   assign thr_s   = $signed({1'b0, threshold});
   assign thr_neg = -thr_s;

   always_comb begin
      cnt_d         = cnt_q + 1'b1;
      curbit_d      = curbit_q;
      fall_max_d    = fall_max_q;
      rise_min_d    = rise_min_q;
      shift_d       = shift_q;
      frame_word_d  = frame_word_q;
      frame_valid_d = 1'b0;
      ssp_clk_d     = ssp_clk_q;
      ssp_frame_d   = ssp_frame_q;
      ssp_din_d     = ssp_din_q;

      // A decision needs both a falling and a rising edge inside one window.
      if (phase == detect_phase) begin
         curbit_d   = (fall_max_q > thr_s) && (rise_min_q < thr_neg);
         fall_max_d = '0;
         rise_min_d = '0;
      end else begin
         if ((f > ZERO_F) && (f > fall_max_q)) fall_max_d = f;
         if ((f <= ZERO_F) && (f < rise_min_q)) rise_min_d = f;
      end

      if (phase == '0) begin
         shift_d   = {shift_q[FB-2:0], curbit_q};
         ssp_din_d = enable & curbit_q;
         ssp_clk_d = 1'b1;
         if (cnt_q == CNT_LAST) begin
            frame_word_d  = {shift_q[FB-2:0], curbit_q};
            frame_valid_d = enable;
         end
      end
      if (phase == HALF_PH) ssp_clk_d = 1'b0;

      if (cnt_q == FR_SET) ssp_frame_d = 1'b1;
      if (cnt_q == FR_CLR) ssp_frame_d = 1'b0;
   end

   always_ff @(posedge ck_1356meg) begin
      if (rst) begin
         cnt_q         <= '0;
         curbit_q      <= 1'b0;
         fall_max_q    <= '0;
         rise_min_q    <= '0;
         shift_q       <= '0;
         frame_word_q  <= '0;
         frame_valid_q <= 1'b0;
         ssp_clk_q     <= 1'b0;
         ssp_frame_q   <= 1'b0;
         ssp_din_q     <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         curbit_q      <= curbit_d;
         fall_max_q    <= fall_max_d;
         rise_min_q    <= rise_min_d;
         shift_q       <= shift_d;
         frame_word_q  <= frame_word_d;
         frame_valid_q <= frame_valid_d;
         ssp_clk_q     <= ssp_clk_d;
         ssp_frame_q   <= ssp_frame_d;
         ssp_din_q     <= ssp_din_d;
      end
   end

   assign curbit      = curbit_q;
   assign ssp_clk     = ssp_clk_q;
   assign ssp_frame   = ssp_frame_q;
   assign ssp_din     = ssp_din_q;
   assign frame_word  = frame_word_q;
   assign frame_valid = frame_valid_q;

`ifdef HF_DEMOD_TIMESTAMP_EN
   lat_state_e      lat_state_q, lat_state_d;
   logic [TS_W-1:0] lat_cnt_q, lat_cnt_d, lat_inc;
   logic [TS_W-1:0] resp_latency_q, resp_latency_d;
   logic            resp_latency_valid_q, resp_latency_valid_d;
   logic            mod_q, mod_d;
   logic            mod_fall, mod_rise, curbit_rise;

   assign mod_fall    = mod_q & ~mod_sig;
   assign mod_rise    = mod_sig & ~mod_q;
   assign curbit_rise = curbit_d & ~curbit_q;
   assign lat_inc     = (&lat_cnt_q) ? lat_cnt_q : lat_cnt_q + 1'b1;

   // Latency includes the edge that registers the curbit rise, hence lat_inc.
   always_comb begin
      lat_state_d          = lat_state_q;
      lat_cnt_d            = lat_cnt_q;
      resp_latency_d       = resp_latency_q;
      resp_latency_valid_d = 1'b0;
      mod_d                = mod_sig;
      if (!enable) begin
         lat_state_d = LAT_IDLE;
      end else if (mod_fall) begin
         lat_state_d = LAT_RUN;
         lat_cnt_d   = '0;
      end else if (lat_state_q == LAT_RUN) begin
         if (mod_rise) begin
            lat_state_d = LAT_IDLE;
         end else if (curbit_rise) begin
            lat_state_d          = LAT_IDLE;
            resp_latency_d       = lat_inc;
            resp_latency_valid_d = 1'b1;
         end else begin
            lat_cnt_d = lat_inc;
         end
      end
   end

   always_ff @(posedge ck_1356meg) begin
      if (rst) begin
         lat_state_q          <= LAT_IDLE;
         lat_cnt_q            <= '0;
         resp_latency_q       <= '0;
         resp_latency_valid_q <= 1'b0;
         mod_q                <= 1'b0;
      end else begin
         lat_state_q          <= lat_state_d;
         lat_cnt_q            <= lat_cnt_d;
         resp_latency_q       <= resp_latency_d;
         resp_latency_valid_q <= resp_latency_valid_d;
         mod_q                <= mod_d;
      end
   end

   assign resp_latency       = resp_latency_q;
   assign resp_latency_valid = resp_latency_valid_q;
`else
   logic unused_mod_sig;
   assign unused_mod_sig     = mod_sig;
   assign resp_latency       = '0;
   assign resp_latency_valid = 1'b0;
`endif

endmodule

// File: tb/tb_hf_subcarrier_demod.sv
// tb/tb_hf_subcarrier_demod.sv - directed self-checking bench for hf_subcarrier_demod
// Latency expectations follow HF_DEMOD_TIMESTAMP_EN.
module tb_hf_subcarrier_demod;
   import hf_pkg::*;

   logic       ck_1356meg = 1'b0;
   logic       rst = 1'b1;
   logic       enable = 1'b1;
   logic [7:0] adc_d = 8'd0;
   logic [9:0] threshold = 10'(DEFAULT_THRESHOLD);
   logic [3:0] detect_phase = 4'd3;
   logic       mod_sig = 1'b0;
   logic       curbit, ssp_clk, ssp_frame, ssp_din, frame_valid, resp_latency_valid;
   logic [7:0] frame_word;
   logic [15:0] resp_latency;

   int total = 0;
   int bad = 0;
   int k = 0;
   int wave_from = 1 << 30;
   int hi = 200, lo = 60, base = 128;
   int fv_n, fv_k, rl_n, rl_k, din_n;
   logic [7:0]  fv_w;
   logic [15:0] rl_v;

`ifdef HF_DEMOD_TIMESTAMP_EN
   localparam bit TS = 1'b1;
`else
   localparam bit TS = 1'b0;
`endif

   hf_subcarrier_demod dut (
      .ck_1356meg         (ck_1356meg),
      .rst                (rst),
      .enable             (enable),
      .adc_d              (adc_d),
      .threshold          (threshold),
      .detect_phase       (detect_phase),
      .mod_sig            (mod_sig),
      .curbit             (curbit),
      .ssp_clk            (ssp_clk),
      .ssp_frame          (ssp_frame),
      .ssp_din            (ssp_din),
      .frame_word         (frame_word),
      .frame_valid        (frame_valid),
      .resp_latency       (resp_latency),
      .resp_latency_valid (resp_latency_valid)
   );

   always #5 ck_1356meg = ~ck_1356meg;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Value presented before edge k+1 sees cnt == k, so phase is k mod 16.
   task automatic drive_adc();
      if (k >= wave_from) adc_d = ((k % 16) < 8) ? 8'(hi) : 8'(lo);
      else                adc_d = 8'(base);
   endtask

   task automatic clear_mon();
      fv_n = 0; fv_k = 0; rl_n = 0; rl_k = 0; din_n = 0; fv_w = '0; rl_v = '0;
   endtask

   task automatic step();
      @(posedge ck_1356meg);
      #1;
      if (rst) k = 0;
      else begin
         k++;
         if (frame_valid)        begin fv_n++; fv_k = k; fv_w = frame_word; end
         if (resp_latency_valid) begin rl_n++; rl_k = k; rl_v = resp_latency; end
         if (ssp_din)            din_n++;
      end
      drive_adc();
   endtask

   task automatic run_to(input int t);
      while (k < t) step();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      mod_sig = 1'b0;
      repeat (3) step();
      rst = 1'b0;
      k = 0;
      clear_mon();
      drive_adc();
   endtask

   task automatic pause(input int t_on, input int t_off);
      run_to(t_on);  mod_sig = 1'b1;
      run_to(t_off); mod_sig = 1'b0;
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // constant input: no edges, empty frames
      wave_from = 1 << 30; base = 128; threshold = 10'd40;
      do_reset();
      chk("rst_curbit", 32'(curbit), 0);
      chk("rst_sspclk", 32'(ssp_clk), 0);
      chk("rst_sspframe", 32'(ssp_frame), 0);
      chk("rst_sspdin", 32'(ssp_din), 0);
      chk("rst_fword", 32'(frame_word), 0);
      chk("rst_fvalid", 32'(frame_valid), 0);
      chk("rst_lat", 32'(resp_latency), 0);
      chk("rst_latv", 32'(resp_latency_valid), 0);
      run_to(112);
      chk("const_nofv", 32'(fv_n), 0);
      run_to(113);
      chk("const_fv", 32'(frame_valid), 1);
      chk("const_fword", 32'(frame_word), 0);
      run_to(300);
      chk("const_fvcnt", 32'(fv_n), 2);
      chk("const_curbit", 32'(curbit), 0);
      chk("const_din", 32'(din_n), 0);

      // 60/200 square wave, edges at phases 0 and 8
      wave_from = 0; hi = 200; lo = 60;
      do_reset();
      run_to(1);   chk("sq_clk_k1", 32'(ssp_clk), 1);
      run_to(7);   chk("sq_frm_k7", 32'(ssp_frame), 0);
      run_to(8);   chk("sq_frm_k8", 32'(ssp_frame), 1);
                   chk("sq_clk_k8", 32'(ssp_clk), 1);
      run_to(9);   chk("sq_clk_k9", 32'(ssp_clk), 0);
      run_to(19);  chk("sq_cb_k19", 32'(curbit), 0);
      run_to(20);  chk("sq_cb_k20", 32'(curbit), 1);
      run_to(23);  chk("sq_frm_k23", 32'(ssp_frame), 1);
      run_to(24);  chk("sq_frm_k24", 32'(ssp_frame), 0);
      run_to(32);  chk("sq_din_k32", 32'(ssp_din), 0);
      run_to(33);  chk("sq_din_k33", 32'(ssp_din), 1);
      run_to(113);
      chk("sq_fv1", 32'(frame_valid), 1);
      chk("sq_fword1", 32'(frame_word), 32'h3F);
      run_to(241);
      chk("sq_fword2", 32'(frame_word), 32'hFF);
      chk("sq_fvcnt", 32'(fv_n), 2);

      // threshold and swing sweeps
      threshold = 10'd500;
      run_to(300); chk("thr500_cb", 32'(curbit), 0);
      hi = 140; lo = 100; threshold = 10'd40;
      run_to(360); chk("small_thr40_cb", 32'(curbit), 1);
      threshold = 10'd130;
      run_to(400); chk("small_thr130_cb", 32'(curbit), 0);

      // reset in the middle of a frame
      hi = 200; lo = 60; threshold = 10'd40;
      do_reset();
      run_to(70);
      chk("mid_cb_before", 32'(curbit), 1);
      chk("mid_din_before", 32'(ssp_din), 1);
      rst = 1'b1;
      step();
      chk("mid_cb", 32'(curbit), 0);
      chk("mid_clk", 32'(ssp_clk), 0);
      chk("mid_din", 32'(ssp_din), 0);
      rst = 1'b0; k = 0; clear_mon(); drive_adc();
      run_to(112); chk("mid_nofv", 32'(fv_n), 0);
      run_to(113); chk("mid_fv", 32'(frame_valid), 1);

      // disabled: detector runs, outputs gated
      enable = 1'b0;
      do_reset();
      pause(10, 50);
      run_to(300);
      chk("dis_cb", 32'(curbit), 1);
      chk("dis_din", 32'(din_n), 0);
      chk("dis_fv", 32'(fv_n), 0);
      chk("dis_rl", 32'(rl_n), 0);
      enable = 1'b1;

      // pause ends at k=51, subcarrier rise decided at k=276
      wave_from = 256;
      do_reset();
      pause(10, 50);
      run_to(275);
      chk("lat_cb_k275", 32'(curbit), 0);
      chk("lat_nopulse", 32'(rl_n), 0);
      run_to(276);
      chk("lat_cb_k276", 32'(curbit), 1);
      chk("lat_valid", 32'(resp_latency_valid), TS ? 1 : 0);
      chk("lat_value", 32'(resp_latency), TS ? 225 : 0);
      run_to(300);
      chk("lat_cnt", 32'(rl_n), TS ? 1 : 0);

      // second pause aborts the run
      do_reset();
      pause(10, 50);
      run_to(100); mod_sig = 1'b1;
      run_to(300);
      chk("abort_cb", 32'(curbit), 1);
      chk("abort_rl", 32'(rl_n), 0);

      // no response for a long time: saturating count
      wave_from = 67200;
      do_reset();
      pause(10, 50);
      run_to(67220);
      chk("sat_cnt", 32'(rl_n), TS ? 1 : 0);
      chk("sat_value", 32'(rl_v), TS ? 32'hFFFF : 0);
      chk("sat_k", 32'(rl_k), TS ? 67220 : 0);
      chk("sat_cb", 32'(curbit), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hf_subcarrier_demod.md
# hf_subcarrier_demod

Parametrised ISO14443-A reader-side receive path for the HF FPGA image. The block filters raw ADC samples with a 5-tap Gaussian-derivative filter and detects the fc/16-class load-modulation subcarrier with a runtime threshold and detection phase. It packs the detected bits into frames, drives the SSP clock, frame and data lines to the ARM, and measures the reader-pause-to-response latency. It replaces the fixed-width, fixed-threshold demodulator in the current fpga_hf top level.

## Interface
Parameters:
- ADC_W, 8: ADC sample width.
- SUBC_LOG2, 4: log2 of subcarrier period in carrier cycles (P = 2^SUBC_LOG2, ≥2).
- FRAME_LOG2, 3: log2 of bits per SSP frame (FB = 2^FRAME_LOG2).
- TS_W, 16: latency counter width.

Ports (one clock, `ck_1356meg`; reset `rst` is synchronous, active-high):
- ck_1356meg  in  1  carrier clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- enable  in  1  reader-listen mode enable.
- adc_d  in  ADC_W  unsigned ADC sample.
- threshold  in  ADC_W+2  unsigned edge magnitude threshold.
- detect_phase  in  SUBC_LOG2  phase at which the detector decides and clears.
- mod_sig  in  1  reader pause active (1 = carrier dropped).
- curbit  out  1  latest modulation decision.
- ssp_clk, ssp_frame, ssp_din  out  1 each  SSP lines to the ARM.
- frame_word  out  FB  last completed frame, MSB = first bit.
- frame_valid  out  1  one-cycle pulse, frame_word updated.
- resp_latency  out  TS_W  cycles from end of pause to first modulation.
- resp_latency_valid  out  1  one-cycle pulse.

## Operation
- Phase counter `cnt` has width SUBC_LOG2+FRAME_LOG2 and free-runs, wrapping from all-ones to 0. `phase = cnt[SUBC_LOG2-1:0]`.
- History: p1 through p4 shift each cycle (p1 <= adc_d).
- Filter, combinational: f = (2·p4 + p3) − (2·adc_d + p1).
  - f is signed ADC_W+3 bits and is computed with zero-extended operands.
  - p2 is unused.
- Detector, when phase == detect_phase:
  - curbit <= (fall_max > threshold) && (rise_min < −threshold).
  - fall_max and rise_min are cleared to 0.
- Detector, on all other phases:
  - If f > 0 and f > fall_max, then fall_max <= f.
  - If f ≤ 0 and f < rise_min, then rise_min <= f.
- Framing, when phase == 0:
  - shift <= {shift[FB-2:0], curbit}.
  - ssp_din <= enable ? curbit : 0.
  - When cnt == P·(FB−1), additionally frame_word <= {shift[FB-2:0], curbit} and frame_valid <= enable.
- SSP lines:
  - ssp_clk <= 1 at phase 0 and 0 at phase P/2.
  - ssp_frame <= 1 at cnt == P/2−1 and 0 at cnt == P/2−1+P.
- Latency FSM, states IDLE and RUN:
  - IDLE → RUN on a falling edge of registered mod_sig; the counter loads 0.
  - In RUN the counter increments each cycle and saturates at all-ones.
  - RUN → IDLE on a curbit 0→1 transition: resp_latency <= count and resp_latency_valid pulses.
  - RUN → IDLE on a mod_sig rise, which aborts with no pulse.
  - RUN → IDLE when enable = 0, with no pulse.
- Simultaneous pause end and curbit rise: the start wins (counter restarts at 0) and no pulse is issued.
- enable = 0: counters and detector keep running; ssp_din, frame_valid and resp_latency_valid are forced 0.

## Timing
- On reset, all outputs, counters, history registers, shift, fall_max, rise_min and FSM state (IDLE) are 0.
- Reset mid-frame or mid-RUN discards everything. The first frame_valid after reset occurs at cnt == P·(FB−1).
- curbit changes one cycle after the decision edge.
- ssp_din changes on the same edge at which ssp_clk rises; the ARM samples on ssp_clk fall.
- frame_valid and frame_word update together, with 1-cycle registered latency from the last-bit edge.
- resp_latency counts the rising edges strictly after the registered mod_sig fall, up to and including the edge that registers the curbit rise.

## Configuration
- HF_DEMOD_TIMESTAMP_EN defined: the latency FSM and counter are built.
- Undefined: resp_latency is tied to 0, resp_latency_valid is tied to 0, and no counter logic is synthesised.
- All other behaviour is identical in both builds.

## Structure
- The shared package `hf_pkg` holds:
  - the mode constants (SNIFFER, TAGSIM_LISTEN, TAGSIM_MOD, READER_LISTEN, READER_MOD);
  - the latency FSM state typedef;
  - the default threshold constant (40).
- One natural sub-module, `hf_edge_filter`: the history registers plus the filter arithmetic, parametrised on ADC_W, output f.

## Test plan
- Constant adc_d = 128, threshold = 40 → f = 0 and curbit stays 0; frame_word = 0x00 pulsed every 128 cycles; ssp_din = 0.
- Square wave 60/200, period 16, aligned so both edges fall inside the detect window (detect_phase = 3) → curbit = 1 from the second decision; frame_word = 0xFF; ssp_frame is high for cycles 7–22 of each frame.
- Same square wave with threshold raised to 500 → curbit = 0.
  - Then apply swing 100/140 with threshold = 40 → |f| peaks near 120 and curbit = 1.
  - With threshold = 130 → curbit = 0.
- mod_sig high for 40 cycles, then low; subcarrier starts 200 cycles later → one resp_latency_valid pulse with resp_latency within ±P of the expected edge count.
  - A second pause during RUN gives no pulse.
  - With no response, the counter saturates at 0xFFFF and is reported when curbit finally rises.
- Assert rst for one cycle at cnt = 70 with curbit = 1 → all outputs 0 on the next cycle; next frame_valid at cnt = 112 after restart.
- enable = 0 with an active subcarrier → curbit toggles as normal, but ssp_din, frame_valid and resp_latency_valid stay 0.
  - Build without HF_DEMOD_TIMESTAMP_EN → latency outputs stay 0 under the test above.
